// File: rtl/mux2.sv
// Registered 2:1 lane multiplexer.
// Picks lane0 or lane1 of a packed input word and registers it, with a
// qualifying valid that travels one cycle behind the sampled inputs.
module mux2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] i,
    input  logic               s,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid
);

    // Stage p0: input lanes and the combinational select, all from the same edge's sample
    logic [WIDTH-1:0] lane0_p0;
    logic [WIDTH-1:0] lane1_p0;
    logic [WIDTH-1:0] sel_p0;
    logic             vld_p0;

    assign lane0_p0 = i[WIDTH-1:0];
    assign lane1_p0 = i[2*WIDTH-1:WIDTH];
    assign vld_p0   = in_valid;

    // Choose the lane named by s; i and s are taken together so lanes never mix
    always_comb begin
        sel_p0 = lane0_p0;
        if (s) begin
            sel_p0 = lane1_p0;
        end
    end

    // Stage p1: output register; data holds while no valid lane arrives
    logic [WIDTH-1:0] y_p1;
    logic             vld_p1;

    // Reset wins over in_valid, discarding any lane presented on that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p1   <= RST_VAL;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                y_p1 <= sel_p0;
            end
        end
    end

    assign y         = y_p1;
    assign out_valid = vld_p1;

`ifndef SYNTHESIS
    // Flag an unknown select on a qualified cycle; the hardware result is unconstrained then
    always @(posedge clk) begin
        if (!rst && in_valid === 1'b1) begin
            assert (!$isunknown(s))
                else $error("mux2: select s is X/Z while in_valid is high");
        end
    end
`endif

endmodule

// File: tb/tb_mux2.sv
// Self-checking bench for mux2: a 1-bit instance and an 8-bit instance with a
// non-zero reset value, each tracked by a small behavioural model.
module tb_mux2;

    logic       clk;
    logic       rst1, rst8;
    logic [1:0] i1;
    logic       s1, iv1;
    logic [0:0] y1;
    logic       ov1;
    logic [15:0] i8;
    logic       s8, iv8;
    logic [7:0] y8;
    logic       ov8;

    int n_pass;
    int n_total;

    // reference model state
    logic [0:0] m_y1;
    logic       m_v1;
    logic [7:0] m_y8;
    logic       m_v8;

    mux2 #(.WIDTH(1), .RST_VAL(1'b0)) u_w1 (
        .clk(clk), .rst(rst1), .i(i1), .s(s1), .in_valid(iv1),
        .y(y1), .out_valid(ov1)
    );

    mux2 #(.WIDTH(8), .RST_VAL(8'hA5)) u_w8 (
        .clk(clk), .rst(rst8), .i(i8), .s(s8), .in_valid(iv8),
        .y(y8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge; the model takes the same inputs, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (rst1) begin
            m_y1 = 1'b0; m_v1 = 1'b0;
        end else if (iv1) begin
            m_y1 = (i1 >> (s1 ? 1 : 0)) & 2'b01; m_v1 = 1'b1;
        end else begin
            m_v1 = 1'b0;
        end
        if (rst8) begin
            m_y8 = 8'hA5; m_v8 = 1'b0;
        end else if (iv8) begin
            m_y8 = 8'((i8 >> (s8 ? 8 : 0)) & 16'h00FF); m_v8 = 1'b1;
        end else begin
            m_v8 = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; i1 = 2'b11; s1 = 1'b1; iv1 = 1'b1;
        rst8 = 1'b1; i8 = 16'hFFFF; s8 = 1'b1; iv8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_total++;
            if (y1 !== 1'b0) $display("FAIL reset_y1 edge%0d: got %b want 0", k, y1);
            else n_pass++;
            n_total++;
            if (ov1 !== 1'b0) $display("FAIL reset_ov1 edge%0d: got %b want 0", k, ov1);
            else n_pass++;
        end
        n_total++;
        if (y8 !== 8'hA5) $display("FAIL reset_y8: got %h want a5", y8);
        else n_pass++;
        n_total++;
        if (ov8 !== 1'b0) $display("FAIL reset_ov8: got %b want 0", ov8);
        else n_pass++;
    endtask

    task automatic test_lane0_sweep();
        logic [0:0] want [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst1 = 1'b0; s1 = 1'b0; iv1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i1 = 2'(k);
            tick();
            n_total++;
            if (y1 !== want[k] || ov1 !== 1'b1)
                $display("FAIL lane0_sweep i=%0d: got y=%b v=%b want y=%b v=1", k, y1, ov1, want[k]);
            else n_pass++;
        end
    endtask

    task automatic test_lane1_sweep();
        logic [0:0] want [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        rst1 = 1'b0; s1 = 1'b1; iv1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i1 = 2'(k);
            tick();
            n_total++;
            if (y1 !== want[k] || ov1 !== 1'b1)
                $display("FAIL lane1_sweep i=%0d: got y=%b v=%b want y=%b v=1", k, y1, ov1, want[k]);
            else n_pass++;
        end
    endtask

    task automatic test_joint_toggle();
        logic [0:0] want;
        rst1 = 1'b0; iv1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i1 = 2'(k % 4);
            s1 = 1'(k % 2);
            want = 1'(((k % 4) >> (k % 2)) % 2);
            tick();
            n_total++;
            if (y1 !== want || ov1 !== 1'b1)
                $display("FAIL joint_toggle k=%0d: got y=%b v=%b want y=%b v=1", k, y1, ov1, want);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        rst1 = 1'b0; iv1 = 1'b1; s1 = 1'b0; i1 = 2'b01;
        tick();
        n_total++;
        if (y1 !== 1'b1 || ov1 !== 1'b1) $display("FAIL hold_load: got y=%b v=%b want y=1 v=1", y1, ov1);
        else n_pass++;
        iv1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i1 = (k % 2 == 0) ? 2'b10 : 2'b00;
            s1 = ~s1;
            tick();
            n_total++;
            if (y1 !== 1'b1 || ov1 !== 1'b0)
                $display("FAIL hold_k%0d: got y=%b v=%b want y=1 v=0", k, y1, ov1);
            else n_pass++;
        end
        iv1 = 1'b1; s1 = 1'b0; i1 = 2'b10;
        tick();
        n_total++;
        if (y1 !== 1'b0 || ov1 !== 1'b1) $display("FAIL hold_resume: got y=%b v=%b want y=0 v=1", y1, ov1);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] want;
        rst8 = 1'b0; iv8 = 1'b1; i8 = {8'hC3, 8'h3C};
        for (int k = 0; k < 4; k++) begin
            s8 = 1'(k % 2);
            want = (k % 2 == 1) ? 8'hC3 : 8'h3C;
            tick();
            n_total++;
            if (y8 !== want || ov8 !== 1'b1)
                $display("FAIL mid_stream k=%0d: got y=%h v=%b want y=%h v=1", k, y8, ov8, want);
            else n_pass++;
        end
        rst8 = 1'b1; s8 = 1'b0;
        tick();
        n_total++;
        if (y8 !== 8'hA5 || ov8 !== 1'b0) $display("FAIL mid_reset: got y=%h v=%b want y=a5 v=0", y8, ov8);
        else n_pass++;
        rst8 = 1'b0; s8 = 1'b1;
        tick();
        n_total++;
        if (y8 !== 8'hC3 || ov8 !== 1'b1) $display("FAIL after_reset: got y=%h v=%b want y=c3 v=1", y8, ov8);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            rst1 = ($urandom_range(0, 19) == 0);
            rst8 = ($urandom_range(0, 19) == 0);
            iv1  = ($urandom_range(0, 3) != 0);
            iv8  = ($urandom_range(0, 3) != 0);
            s1   = 1'($urandom);
            s8   = 1'($urandom);
            i1   = 2'($urandom);
            i8   = 16'($urandom);
            tick();
            n_total++;
            if (y1 !== m_y1 || ov1 !== m_v1)
                $display("FAIL random_w1 k=%0d: got y=%b v=%b want y=%b v=%b", k, y1, ov1, m_y1, m_v1);
            else n_pass++;
            n_total++;
            if (y8 !== m_y8 || ov8 !== m_v8)
                $display("FAIL random_w8 k=%0d: got y=%h v=%b want y=%h v=%b", k, y8, ov8, m_y8, m_v8);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        m_y1 = 1'b0; m_v1 = 1'b0; m_y8 = 8'h00; m_v8 = 1'b0;
        rst1 = 1'b1; rst8 = 1'b1;
        i1 = 2'b00; s1 = 1'b0; iv1 = 1'b0;
        i8 = 16'h0000; s8 = 1'b0; iv8 = 1'b0;
        #1;
        test_reset();
        test_lane0_sweep();
        test_lane1_sweep();
        test_joint_toggle();
        test_hold();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
